rv_multicycle_core: RTL and testbench

- Parametrised multi-cycle RISC-V core. It is the successor to the single-cycle processor top.
- Each instruction is sequenced through an FSM over FETCH/DECODE/EXEC/MEM/WB. Instruction and data memories are external and reached through req/valid handshakes, so variable-latency memories are supported.
- The core adds an ADDI path, a precise illegal-opcode trap, and a retire strobe.

---
 rtl/rv_mc_pkg.sv | 56 +++++
 rtl/rv_mc_regfile.sv | 42 ++++
 rtl/rv_multicycle_core.sv | 190 +++++++++++++++++++
 tb/tb_rv_multicycle_core.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mc_pkg.sv
// Purpose: shared encodings for the multi-cycle RV core (opcodes, funct fields, FSM states, ALU ops).
// Latency: n/a (constants and a pure combinational legality check).
// Backpressure: n/a.
package rv_mc_pkg;

  // Major opcodes of the supported subset
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_LDST    = 3'b011;  // doubleword ld/sd
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // FSM states
  typedef logic [2:0] state_t;
  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_MEM    = 3'd3;
  localparam state_t S_WB     = 3'd4;
  localparam state_t S_TRAP   = 3'd5;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  // True when opcode/funct3/funct7 name an instruction of the supported subset.
  function automatic logic insn_legal(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_R:   ok = ((f7 == F7_BASE) && (f3 == F3_ADD_SUB || f3 == F3_OR || f3 == F3_AND)) ||
                   ((f7 == F7_SUB) && (f3 == F3_ADD_SUB));
      OP_IMM: ok = (f3 == F3_ADDI);
      OP_LD:  ok = (f3 == F3_LDST);
      OP_ST:  ok = (f3 == F3_LDST);
      OP_BR:  ok = (f3 == F3_BEQ);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rv_mc_regfile.sv
// Purpose: architectural register file, x0 hard-wired to zero.
// Latency: reads combinational, write lands on the next rising clk edge.
// Backpressure: none; single write port, always accepts.
// Ports: clk/reset (sync, active-high, clears all registers); rs1/rs2 read
//   addresses with rs1_dat/rs2_dat data; we/rd/wdata write port.
module rv_mc_regfile #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rs1_dat,
  output logic [XLEN-1:0] rs2_dat,
  input  logic            we,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] wdata
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] regs [NREGS];
  logic [AW-1:0]   ra1, ra2, wa;

  // With a 16-entry file only the low address bits select a register.
  assign ra1 = rs1[AW-1:0];
  assign ra2 = rs2[AW-1:0];
  assign wa  = rd[AW-1:0];

  assign rs1_dat = (ra1 == '0) ? '0 : regs[ra1];
  assign rs2_dat = (ra2 == '0) ? '0 : regs[ra2];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wdata;
    end
  end

endmodule

// File: rtl/rv_multicycle_core.sv
// Purpose: multi-cycle RV core (FETCH/DECODE/EXEC/MEM/WB) with precise illegal-opcode trap.
// Latency: zero-wait memories give beq 3, sd 4, R/addi 4, ld 5 cycles per instruction.
// Backpressure: FETCH/MEM hold request, address and data stable until imem_valid/dmem_valid.
// Ports: clk, reset (sync, active-high); imem_req/addr/valid/rdata fetch handshake;
//   dmem_req/we/addr/wdata/valid/rdata data handshake; pc_o, retire (1-cycle pulse),
//   halted (sticky trap), instret (counter only when RV_MC_INSTRET_EN is defined, else 0).
module rv_multicycle_core
  import rv_mc_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              NREGS    = 32
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_valid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] pc_o,
  output logic            retire,
  output logic            halted,
  output logic [63:0]     instret
);

  state_t          state;
  logic [XLEN-1:0] pc, a, b, imm, res;
  logic [31:0]     ir;

  // Instruction fields
  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];

  logic [XLEN-1:0] rs1_dat, rs2_dat;

  rv_mc_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .rs1     (rs1),
    .rs2     (rs2),
    .rs1_dat (rs1_dat),
    .rs2_dat (rs2_dat),
    .we      ((state == S_WB) && !reset),
    .rd      (rd),
    .wdata   (res)
  );

  // Immediate decode, sign-extended to XLEN
  logic [XLEN-1:0] imm_dec;
  always_comb begin
    imm_dec = '0;
    case (opcode)
      OP_IMM, OP_LD: imm_dec = {{(XLEN-12){ir[31]}}, ir[31:20]};
      OP_ST:         imm_dec = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
      OP_BR:         imm_dec = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default:       imm_dec = '0;
    endcase
  end

  // ALU: only R-type funct3 000 may subtract; addi immediates can set IR[30].
  alu_op_e         alu_op;
  logic [XLEN-1:0] alu_b, alu_y;
  always_comb begin
    alu_op = ALU_ADD;
    if (opcode == OP_R) begin
      case (f3)
        F3_ADD_SUB: alu_op = ir[30] ? ALU_SUB : ALU_ADD;
        F3_OR:      alu_op = ALU_OR;
        F3_AND:     alu_op = ALU_AND;
        default:    alu_op = ALU_ADD;
      endcase
    end
  end

  assign alu_b = (opcode == OP_R) ? b : imm;

  always_comb begin
    alu_y = a + alu_b;
    case (alu_op)
      ALU_ADD: alu_y = a + alu_b;
      ALU_SUB: alu_y = a - alu_b;
      ALU_AND: alu_y = a & alu_b;
      ALU_OR:  alu_y = a | alu_b;
      default: alu_y = a + alu_b;
    endcase
  end

  logic [XLEN-1:0] pc_plus4, br_target;
  assign pc_plus4  = pc + XLEN'(4);
  assign br_target = pc + imm;

  logic is_st, is_ld, is_br;
  assign is_st = (opcode == OP_ST);
  assign is_ld = (opcode == OP_LD);
  assign is_br = (opcode == OP_BR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      a     <= '0;
      b     <= '0;
      imm   <= '0;
      res   <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_valid) begin
            ir    <= imem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a     <= rs1_dat;
          b     <= rs2_dat;
          imm   <= imm_dec;
          state <= insn_legal(opcode, f3, f7) ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          res <= alu_y;
          if (is_br) begin
            pc    <= (a == b) ? br_target : pc_plus4;
            state <= S_FETCH;
          end else if (is_ld || is_st) begin
            state <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          // res holds the address for the whole access so dmem outputs stay stable.
          if (dmem_valid) begin
            if (is_st) begin
              pc    <= pc_plus4;
              state <= S_FETCH;
            end else begin
              res   <= dmem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          pc    <= pc_plus4;
          state <= S_FETCH;
        end
        S_TRAP: state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

  assign imem_req   = (state == S_FETCH) && !reset;
  assign imem_addr  = pc;
  assign dmem_req   = (state == S_MEM) && !reset;
  assign dmem_we    = (state == S_MEM) && is_st && !reset;
  assign dmem_addr  = res;
  assign dmem_wdata = b;
  assign pc_o       = pc;
  assign halted     = (state == S_TRAP) && !reset;

  assign retire = !reset && (((state == S_EXEC) && is_br) ||
                             ((state == S_MEM) && is_st && dmem_valid) ||
                             (state == S_WB));

`ifdef RV_MC_INSTRET_EN
  logic [63:0] instret_q;
  always_ff @(posedge clk) begin
    if (reset)       instret_q <= '0;
    else if (retire) instret_q <= instret_q + 64'd1;
  end
  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_rv_multicycle_core.sv
// Purpose: directed self-checking bench for rv_multicycle_core with a small imem/dmem model.
// Latency: imem is zero-wait; dmem answers after dlat wait cycles (bench-controlled).
// Backpressure: dmem_valid is withheld for dlat cycles to exercise the MEM hold behaviour.
module tb_rv_multicycle_core;

  localparam int XLEN = 64;
  localparam logic [31:0] NOP = 32'h00000013;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            imem_req, imem_valid;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            dmem_req, dmem_we, dmem_valid;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata, pc_o;
  logic            retire, halted;
  logic [63:0]     instret;

  int n_vec = 0;
  int n_err = 0;
  int dlat = 0;
  int dcnt = 0;
  int n_ret = 0;
  int cyc_acc = 0;

  logic [31:0] imem [0:63];
  logic [63:0] dmem [0:63];

  rv_multicycle_core #(.XLEN(XLEN), .RESET_PC('0), .NREGS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_valid (dmem_valid),
    .dmem_rdata (dmem_rdata),
    .pc_o       (pc_o),
    .retire     (retire),
    .halted     (halted),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  // Memory model
  assign imem_valid = imem_req;
  assign imem_rdata = imem[imem_addr[7:2]];
  assign dmem_valid = dmem_req && (dcnt >= dlat);
  assign dmem_rdata = dmem[dmem_addr[8:3]];

  always @(posedge clk) begin
    if (dmem_req && !dmem_valid) dcnt <= dcnt + 1;
    else                         dcnt <= 0;
    if (dmem_req && dmem_valid && dmem_we) dmem[dmem_addr[8:3]] <= dmem_wdata;
    if (reset)       n_ret <= 0;
    else if (retire) n_ret <= n_ret + 1;
  end

  // Encoders
  function automatic logic [31:0] e_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] e_ld(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm, rs1, 3'b011, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] e_sd(input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] e_beq(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = NOP;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Counts cycles up to and including the retire cycle, then steps past it.
  task automatic wait_retire(input string name);
    int k;
    k = 0;
    while (!retire && k < 40) begin
      cyc();
      k++;
    end
    cyc_acc += k + 1;
    if (!retire) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no retire within 40 cycles", name);
    end
    cyc();
  endtask

  task automatic wait_dreq(input string name);
    int k;
    k = 0;
    while (!dmem_req && k < 40) begin
      cyc();
      k++;
    end
    if (!dmem_req) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no dmem_req within 40 cycles", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    n_vec++;
    if ({imem_req, dmem_req, dmem_we, retire, halted} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 00000", {imem_req, dmem_req, dmem_we, retire, halted});
    end
    n_vec++;
    if (pc_o !== 64'h0 || instret !== 64'h0) begin
      n_err++;
      $display("FAIL reset_pc_instret: got pc=%h instret=%h expected 0/0", pc_o, instret);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      n_err++;
      $display("FAIL reset_first_fetch: got req=%b addr=%h expected 1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_addi_add();
    dlat = 0;
    clear_imem();
    imem[0] = e_addi(5'd1, 5'd0, 12'h005);
    imem[1] = e_addi(5'd2, 5'd0, 12'hFFD);
    imem[2] = e_r(7'b0000000, 3'b000, 5'd3, 5'd1, 5'd2);
    imem[3] = e_sd(5'd3, 5'd0, 12'h100);
    reset_dut();
    cyc_acc = 0;
    wait_retire("addi1");
    wait_retire("addi2");
    wait_retire("add");
    n_vec++;
    if (cyc_acc !== 12) begin
      n_err++;
      $display("FAIL prog_cycles: got %0d expected 12", cyc_acc);
    end
    n_vec++;
    if (n_ret !== 3) begin
      n_err++;
      $display("FAIL prog_retires: got %0d expected 3", n_ret);
    end
    wait_dreq("sd_x3");
    n_vec++;
    if (dmem_we !== 1'b1 || dmem_addr !== 64'h100 || dmem_wdata !== 64'h2) begin
      n_err++;
      $display("FAIL x3_value: got we=%b addr=%h data=%h expected 1/100/2", dmem_we, dmem_addr, dmem_wdata);
    end
    wait_retire("sd_x3");
  endtask

  task automatic test_load_store();
    int waits, bad;
    dlat = 3;
    dmem[16] = 64'hDEADBEEF;
    dmem[32] = 64'h0;
    dmem[33] = 64'h0;
    clear_imem();
    imem[0] = e_ld(5'd1, 5'd0, 12'h080);
    imem[1] = e_sd(5'd1, 5'd0, 12'h100);
    imem[2] = e_ld(5'd4, 5'd0, 12'h100);
    imem[3] = e_sd(5'd4, 5'd0, 12'h108);
    reset_dut();
    wait_retire("ld_x1");
    wait_dreq("sd_x1");
    waits = 0;
    bad = 0;
    while (!dmem_valid && waits < 20) begin
      if (dmem_addr !== 64'h100 || dmem_wdata !== 64'hDEADBEEF || dmem_we !== 1'b1) bad++;
      waits++;
      cyc();
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL sd_hold_stable: got %0d unstable cycles expected 0", bad);
    end
    n_vec++;
    if (waits !== 3) begin
      n_err++;
      $display("FAIL sd_wait_cycles: got %0d expected 3", waits);
    end
    wait_retire("sd_x1");
    n_vec++;
    if (dmem[32] !== 64'hDEADBEEF) begin
      n_err++;
      $display("FAIL sd_mem_write: got %h expected deadbeef", dmem[32]);
    end
    wait_retire("ld_x4");
    wait_dreq("sd_x4");
    n_vec++;
    if (dmem_addr !== 64'h108 || dmem_wdata !== 64'hDEADBEEF) begin
      n_err++;
      $display("FAIL ld_x4_value: got addr=%h data=%h expected 108/deadbeef", dmem_addr, dmem_wdata);
    end
    wait_retire("sd_x4");
  endtask

  task automatic test_branch();
    dlat = 0;
    for (int pass = 0; pass < 2; pass++) begin
      clear_imem();
      imem[0] = e_addi(5'd1, 5'd0, 12'h005);
      imem[1] = e_addi(5'd2, 5'd0, 12'h007);
      imem[8] = (pass == 0) ? e_beq(5'd1, 5'd1, 13'd8) : e_beq(5'd1, 5'd2, 13'd8);
      reset_dut();
      for (int i = 0; i < 8; i++) wait_retire("pre_branch");
      cyc_acc = 0;
      wait_retire("beq");
      n_vec++;
      if (cyc_acc !== 3) begin
        n_err++;
        $display("FAIL beq_cycles_%0d: got %0d expected 3", pass, cyc_acc);
      end
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== ((pass == 0) ? 64'h28 : 64'h24)) begin
        n_err++;
        $display("FAIL beq_next_fetch_%0d: got req=%b addr=%h expected 1/%h", pass, imem_req, imem_addr,
                 (pass == 0) ? 64'h28 : 64'h24);
      end
    end
  endtask

  task automatic test_trap();
    int bad;
    clear_imem();
    imem[16] = 32'h0000007F;
    reset_dut();
    for (int i = 0; i < 16; i++) wait_retire("pre_trap");
    cyc();
    cyc();
    n_vec++;
    if (halted !== 1'b1 || pc_o !== 64'h40) begin
      n_err++;
      $display("FAIL trap_state: got halted=%b pc=%h expected 1/40", halted, pc_o);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (imem_req !== 1'b0 || dmem_req !== 1'b0 || retire !== 1'b0 || halted !== 1'b1) bad++;
      cyc();
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL trap_quiet: got %0d active cycles expected 0", bad);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    n_vec++;
    if (halted !== 1'b0 || pc_o !== 64'h0 || imem_addr !== 64'h0) begin
      n_err++;
      $display("FAIL trap_exit: got halted=%b pc=%h expected 0/0", halted, pc_o);
    end
    // Unsupported funct7 on an R-type opcode also traps at its own PC.
    clear_imem();
    imem[0] = e_r(7'b0000001, 3'b000, 5'd3, 5'd1, 5'd2);
    reset_dut();
    cyc();
    cyc();
    n_vec++;
    if (halted !== 1'b1 || pc_o !== 64'h0) begin
      n_err++;
      $display("FAIL trap_funct7: got halted=%b pc=%h expected 1/0", halted, pc_o);
    end
  endtask

  task automatic test_reset_mid_mem();
    dlat = 20;
    dmem[32] = 64'h1234;
    clear_imem();
    imem[0] = e_sd(5'd0, 5'd0, 12'h100);
    reset_dut();
    wait_dreq("mid_mem_sd");
    cyc();
    reset = 1'b1;
    #1;
    n_vec++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin
      n_err++;
      $display("FAIL midmem_gate: got req=%b we=%b expected 0/0", dmem_req, dmem_we);
    end
    cyc();
    n_vec++;
    if (dmem_req !== 1'b0 || imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL midmem_in_reset: got dreq=%b ireq=%b expected 0/0", dmem_req, imem_req);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0 || dmem_req !== 1'b0) begin
      n_err++;
      $display("FAIL midmem_restart: got ireq=%b addr=%h dreq=%b expected 1/0/0", imem_req, imem_addr, dmem_req);
    end
    n_vec++;
    if (dmem[32] !== 64'h1234) begin
      n_err++;
      $display("FAIL midmem_no_write: got %h expected 1234", dmem[32]);
    end
  endtask

  task automatic test_alu_x0_instret();
    logic [63:0] exp_instret;
    dlat = 0;
    for (int i = 34; i < 38; i++) dmem[i] = 64'h5A5A;
    clear_imem();
    imem[0] = e_addi(5'd0, 5'd0, 12'h001);
    imem[1] = e_addi(5'd1, 5'd0, 12'hFFF);
    imem[2] = e_r(7'b0000000, 3'b000, 5'd2, 5'd1, 5'd1);
    imem[3] = e_r(7'b0100000, 3'b000, 5'd3, 5'd1, 5'd2);
    imem[4] = e_r(7'b0000000, 3'b111, 5'd5, 5'd1, 5'd2);
    imem[5] = e_r(7'b0000000, 3'b110, 5'd6, 5'd3, 5'd2);
    imem[6] = e_sd(5'd0, 5'd0, 12'h110);
    imem[7] = e_sd(5'd5, 5'd0, 12'h118);
    imem[8] = e_sd(5'd3, 5'd0, 12'h120);
    imem[9] = e_sd(5'd6, 5'd0, 12'h128);
    reset_dut();
    for (int i = 0; i < 10; i++) wait_retire("alu_prog");
`ifdef RV_MC_INSTRET_EN
    exp_instret = 64'd10;
`else
    exp_instret = 64'd0;
`endif
    n_vec++;
    if (instret !== exp_instret) begin
      n_err++;
      $display("FAIL instret: got %0d expected %0d", instret, exp_instret);
    end
    n_vec++;
    if (n_ret !== 10) begin
      n_err++;
      $display("FAIL retire_pulses: got %0d expected 10", n_ret);
    end
    n_vec++;
    if (dmem[34] !== 64'h0) begin
      n_err++;
      $display("FAIL x0_hardzero: got %h expected 0", dmem[34]);
    end
    n_vec++;
    if (dmem[35] !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      n_err++;
      $display("FAIL add_and_wrap: got %h expected fffffffffffffffe", dmem[35]);
    end
    n_vec++;
    if (dmem[36] !== 64'h1) begin
      n_err++;
      $display("FAIL sub: got %h expected 1", dmem[36]);
    end
    n_vec++;
    if (dmem[37] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_err++;
      $display("FAIL or: got %h expected ffffffffffffffff", dmem[37]);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) dmem[i] = 64'h0;
    clear_imem();
    test_reset();
    test_addi_add();
    test_load_store();
    test_branch();
    test_trap();
    test_reset_mid_mem();
    test_alu_x0_instret();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
